weight_fetch: RTL and testbench

Upstream feeder for `weight_fifo`. On a start command it streams a contiguous block of 32-byte weight rows out of the weight memory. It pushes those rows into the weight FIFO through the FIFO's request/sending handshake. A small credit-controlled prefetch buffer hides the memory read latency. With this buffer the block sustains one row per cycle whenever the FIFO keeps requesting.

---
 rtl/weight_fetch.sv | 172 +++++++++++++++++
 tb/tb_weight_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch.sv
// weight_fetch: streams a contiguous block of 32-byte weight rows from memory into weight_fifo.
// Defining WEIGHT_FETCH_PERF_EN adds the stall_cycles_o back-pressure counter.
module weight_fetch #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [7:0]        num_tiles_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0][7:0]  mem_data_i,
  input  logic              fifo_request_i,
  output logic              write_en_o,
  output logic              sending_data_o,
  output logic [31:0][7:0]  data_o,
  output logic              busy_o,
  output logic              done_o
`ifdef WEIGHT_FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cycles_o
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [12:0]         total_q, total_d;
  logic [12:0]         issued_q, issued_d;
  logic [12:0]         xfer_q, xfer_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_LAT-1:0]  tag_q, tag_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     occ_q, occ_d;
  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wen_q, wen_d;
  logic [31:0][7:0]    row_q [BUF_DEPTH];

  logic                rd_en;
  logic                ret_vld;
  logic                sending;
  logic                pop;
  logic [CntW:0]       credit_used;

  always_comb begin
    credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
    // Credits use registered counts only, so a same-cycle pop never frees a slot early.
    rd_en   = (state_q == StRun) && (issued_q < total_q) &&
              (credit_used < (CntW + 1)'(BUF_DEPTH));
    ret_vld = tag_q[MEM_LAT-1];
    sending = (occ_q != '0);
    pop     = sending && fifo_request_i;
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    issued_d   = issued_q + 13'(rd_en);
    xfer_d     = xfer_q + 13'(pop);
    addr_d     = rd_en ? addr_q + ADDR_W'(1) : addr_q;
    tag_d      = MEM_LAT'({tag_q, rd_en});
    inflight_d = inflight_q + CntW'(rd_en) - CntW'(ret_vld);
    occ_d      = occ_q + CntW'(ret_vld) - CntW'(pop);
    head_d     = head_q;
    tail_d     = tail_q;
    if (pop) begin
      head_d = (head_q == PtrW'(BUF_DEPTH - 1)) ? '0 : head_q + PtrW'(1);
    end
    if (ret_vld) begin
      tail_d = (tail_q == PtrW'(BUF_DEPTH - 1)) ? '0 : tail_q + PtrW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          total_d  = {num_tiles_i, 5'b0};
          issued_d = '0;
          xfer_d   = '0;
          addr_d   = base_addr_i;
          state_d  = (num_tiles_i == 8'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issued_d == total_q) state_d = StDrain;
      end
      StDrain: begin
        if (xfer_d == total_q && inflight_d == '0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StDrain);
    wen_d  = busy_d;
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      total_q    <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      xfer_q     <= xfer_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wen_q      <= wen_d;
    end
  end

  // Row storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk_i) begin
    if (ret_vld) row_q[tail_q] <= mem_data_i;
  end

  assign mem_rd_en_o    = rd_en;
  assign mem_addr_o     = addr_q;
  assign sending_data_o = sending;
  assign data_o         = sending ? row_q[head_q] : '0;
  assign write_en_o     = wen_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && start_i) begin
      stall_d = '0;
    end else if (sending && !fifo_request_i && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: vector table, corner sequences, randomized jobs.
module tb_weight_fetch;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MEM_LAT   = 2;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int          LIMIT     = 2000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [7:0]        num_tiles_i;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0][7:0]  mem_data_i;
  logic              fifo_request_i;
  logic              write_en_o;
  logic              sending_data_o;
  logic [31:0][7:0]  data_o;
  logic              busy_o;
  logic              done_o;
`ifdef WEIGHT_FETCH_PERF_EN
  logic [15:0]       stall_cycles_o;
`endif

  always #5 clk = ~clk;

  weight_fetch #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .num_tiles_i    (num_tiles_i),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_i     (mem_data_i),
    .fifo_request_i (fifo_request_i),
    .write_en_o     (write_en_o),
    .sending_data_o (sending_data_o),
    .data_o         (data_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  function automatic logic [255:0] row_of(input logic [15:0] a);
    return {16{a}};
  endfunction

  // Memory model: fixed-latency pipeline returning the row address as payload, garbage otherwise.
  bit [MEM_LAT-1:0] pv;
  bit [15:0]        pa [MEM_LAT];
  bit [255:0]       garb;
  always @(posedge clk) begin
    pv[0] <= mem_rd_en_o;
    pa[0] <= mem_addr_o;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    garb <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  end
  assign mem_data_i = pv[MEM_LAT-1] ? row_of(pa[MEM_LAT-1]) : garb;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log for the current job.
  bit          mon_en = 1'b0;
  logic [15:0] rd_addr_q[$];
  logic [15:0] xf_addr_q[$];
  int rd_cnt, xf_cnt, max_out, done_cnt, done_rel, first_rel, last_rel, bad_data, we_bad;

  always @(negedge clk) begin
    if (!mon_en) begin
      rd_addr_q.delete();
      xf_addr_q.delete();
      rd_cnt <= 0; xf_cnt <= 0; max_out <= 0; done_cnt <= 0; done_rel <= -1;
      first_rel <= -1; last_rel <= -1; bad_data <= 0; we_bad <= 0;
    end else begin
      if (mem_rd_en_o) begin
        rd_addr_q.push_back(mem_addr_o);
        rd_cnt <= rd_cnt + 1;
        if (rd_cnt + 1 - xf_cnt > max_out) max_out <= rd_cnt + 1 - xf_cnt;
      end
      if (sending_data_o && fifo_request_i) begin
        xf_addr_q.push_back({data_o[1], data_o[0]});
        if (data_o != row_of({data_o[1], data_o[0]})) bad_data <= bad_data + 1;
        if (first_rel < 0) first_rel <= cyc - t0;
        last_rel <= cyc - t0;
        xf_cnt   <= xf_cnt + 1;
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_rel <= cyc - t0;
      end
      if ((write_en_o !== busy_o) || (done_o && busy_o)) we_bad <= we_bad + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit req_at(input int mode, input int k, input int lo_a, input int lo_b,
                                input int pct);
    if (mode == 1) return !(k >= lo_a && k <= lo_b);
    if (mode == 2) return int'($urandom_range(99)) < pct;
    return 1'b1;
  endfunction

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] base, input int tiles, input int mode,
                         input int lo_a, input int lo_b, input int pct, input int poke_k);
    mon_en = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    t0             = cyc;
    start_i        = 1'b1;
    base_addr_i    = base;
    num_tiles_i    = 8'(tiles);
    fifo_request_i = req_at(mode, 0, lo_a, lo_b, pct);
    mon_en         = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk); #1;
      start_i = (k == poke_k);
      if (k == poke_k) begin
        base_addr_i = 16'h7777;
        num_tiles_i = 8'd9;
      end
      fifo_request_i = req_at(mode, k, lo_a, lo_b, pct);
      @(negedge clk); #1;
      if (done_cnt > 0) break;
    end
    mon_en = 1'b0;
    if (done_cnt == 0) begin
      $display("FAIL job_timeout: no done_o within %0d cycles", LIMIT);
      pulse_reset();
    end
  endtask

  task automatic check_job(input logic [15:0] base, input int tiles, input int e_first,
                           input int e_last, input int e_done, input int e_stall);
    int total, bad_x, bad_r;
    total = tiles * 32;
    bad_x = 0;
    bad_r = 0;
    foreach (xf_addr_q[i]) if (xf_addr_q[i] != 16'(base + 16'(i))) bad_x++;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] != 16'(base + 16'(i))) bad_r++;
    check("xfer_count", xf_cnt, total);
    check("read_count", rd_cnt, total);
    check("xfer_order_errors", bad_x, 0);
    check("read_addr_errors", bad_r, 0);
    check("row_payload_errors", bad_data, 0);
    check("outstanding_within_depth", longint'(max_out <= BUF_DEPTH), 1);
    check("done_pulses", done_cnt, 1);
    check("write_en_busy_errors", we_bad, 0);
    if (total > 0) check("done_after_last_xfer", done_rel, last_rel + 1);
    else           check("done_cycle_empty", done_rel, 1);
    if (e_first >= 0) check("first_xfer_cycle", first_rel, e_first);
    if (e_last >= 0)  check("last_xfer_cycle", last_rel, e_last);
    if (e_done >= 0)  check("done_cycle", done_rel, e_done);
`ifdef WEIGHT_FETCH_PERF_EN
    if (e_stall >= 0) check("stall_cycles", stall_cycles_o, e_stall);
`endif
  endtask

  typedef struct {
    logic [15:0] base;
    int tiles, mode, lo_a, lo_b, e_first, e_last, e_done, e_stall;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [15:0] rb;
    int          rt;
    int          pre_xf;
    int          pre_rd;

    vecs[0] = '{16'h0100, 1, 0, 0, 0,  4, 35, 36,  0};
    vecs[1] = '{16'h0100, 1, 1, 6, 15, 4, 45, 46, 10};
    vecs[2] = '{16'hFFF0, 1, 0, 0, 0,  4, 35, 36,  0};
    vecs[3] = '{16'h1234, 0, 0, 0, 0, -1, -1,  1,  0};
    vecs[4] = '{16'h4000, 2, 0, 0, 0,  4, 67, 68,  0};

    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_tiles_i = '0; fifo_request_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_rd_en", mem_rd_en_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_write_en", write_en_o, 0);
    check("reset_sending", sending_data_o, 0);
    check("reset_data_nonzero", longint'(data_o != '0), 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].base, vecs[v].tiles, vecs[v].mode, vecs[v].lo_a, vecs[v].lo_b, 100, 0);
      check_job(vecs[v].base, vecs[v].tiles, vecs[v].e_first, vecs[v].e_last, vecs[v].e_done,
                vecs[v].e_stall);
    end

    // start_i during RUN with another base must be ignored.
    run_job(16'h0300, 1, 0, 0, 0, 100, 5);
    check_job(16'h0300, 1, 4, 35, 36, 0);

    // Asynchronous reset in cycle 10 of a 2-tile run.
    mon_en = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    t0 = cyc; start_i = 1'b1; base_addr_i = 16'h0500; num_tiles_i = 8'd2; fifo_request_i = 1'b1;
    mon_en = 1'b1;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    check("midreset_mem_rd_en", mem_rd_en_o, 0);
    check("midreset_mem_addr", mem_addr_o, 0);
    check("midreset_sending", sending_data_o, 0);
    check("midreset_data_nonzero", longint'(data_o != '0), 0);
    check("midreset_busy_wen", {busy_o, write_en_o, done_o}, 0);
    pre_xf = xf_cnt;
    pre_rd = rd_cnt;
    check("pre_reset_xfers", pre_xf, 6);
    begin
      int bad;
      bad = 0;
      foreach (xf_addr_q[i]) if (xf_addr_q[i] != 16'(16'h0500 + 16'(i))) bad++;
      check("pre_reset_order_errors", bad, 0);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check("post_reset_xfers", xf_cnt - pre_xf, 0);
    check("post_reset_reads", rd_cnt - pre_rd, 0);
    check("post_reset_done", done_cnt, 0);
    run_job(16'h2000, 1, 0, 0, 0, 100, 0);
    check_job(16'h2000, 1, 4, 35, 36, 0);

    // Randomized jobs against the ordering/count/timing model.
    for (int j = 0; j < 12; j++) begin
      rb = 16'($urandom);
      rt = int'($urandom_range(3));
      run_job(rb, rt, 2, 0, 0, int'($urandom_range(100, 25)), 0);
      check_job(rb, rt, -1, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
